// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the sram-like to AXI3 arbiter/bridge.
// Includes the FSM state encoding, AXI burst/size constants and the byte-strobe helper.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  // sram-like size 3 has no AXI meaning here, so it is treated as a word
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? AXI_SIZE_WORD : {1'b0, size};
  endfunction

  function automatic logic [3:0] wstrb_from(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_grant.sv
// N-way request arbiter producing a one-hot grant and its index.
// ARB_ROUND_ROBIN_EN selects rotating priority; otherwise the lowest index wins.
module sram_like_grant
  import axi_bridge_pkg::*;
#(
  parameter int unsigned N_PORTS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic               advance,
  output logic [N_PORTS-1:0] gnt,
  output logic [2:0]         idx,
  output logic               any
);

  logic [2:0] base;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = 3'((32'(idx) + 32'd1) % N_PORTS);
  end

  assign base = ptr_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, advance};
  assign base = '0;
`endif

  // Rotate the request vector so the search always starts at bit 0.
  logic [2*N_PORTS-1:0] req_rot;
  int unsigned          sel;

  always_comb begin
    req_rot = {req, req} >> base;
    any     = 1'b0;
    sel     = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (!any && req_rot[k]) begin
        any = 1'b1;
        sel = (32'(base) + k) % N_PORTS;
      end
    end
    idx = 3'(sel);
    gnt = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      gnt[j] = any && (sel == j);
    end
  end

endmodule

// File: rtl/axi_sram_like_arbiter.sv
// Arbitrates N sram-like masters onto one AXI3 master port, one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN (in sram_like_grant) enables rotating priority.
module axi_sram_like_arbiter
  import axi_bridge_pkg::*;
#(
  parameter int unsigned N_PORTS  = 2,
  parameter int unsigned MAX_RLEN = 16,
  parameter int unsigned LEN_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS-1:0]       m_req,
  input  logic [N_PORTS-1:0]       m_wr,
  input  logic [2*N_PORTS-1:0]     m_size,
  input  logic [32*N_PORTS-1:0]    m_addr,
  input  logic [32*N_PORTS-1:0]    m_wdata,
  input  logic [LEN_W*N_PORTS-1:0] m_rlen,
  output logic [N_PORTS-1:0]       m_addr_ok,
  output logic [N_PORTS-1:0]       m_data_ok,
  output logic [31:0]              m_rdata,
  output logic                     m_rlast,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int unsigned CNT_W = $clog2(MAX_RLEN) + 1;

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] gnt_q, gnt_d;
  logic [2:0]         g_q, g_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         rlen_q, rlen_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_PORTS-1:0] gnt;
  logic [2:0]         gidx;
  logic               gany;

  // Response ids and error codes are deliberately ignored with one outstanding transaction.
  logic unused_axi;
  assign unused_axi = ^{rid, rresp, bid, bresp};

  sram_like_grant #(
    .N_PORTS (N_PORTS)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .req     (m_req),
    .advance ((state_q == ST_IDLE) && gany),
    .gnt     (gnt),
    .idx     (gidx),
    .any     (gany)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      g_q       <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rlen_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      g_q       <= g_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rlen_q    <= rlen_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    g_d       = g_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rlen_d    = rlen_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gany) begin
          gnt_d     = gnt;
          g_d       = gidx;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (gnt[p]) begin
              wr_d    = m_wr[p];
              size_d  = m_size[p*2 +: 2];
              addr_d  = m_addr[p*32 +: 32];
              wdata_d = m_wdata[p*32 +: 32];
              rlen_d  = 4'(m_rlen[p*LEN_W +: LEN_W]);
            end
          end
          state_d = wr_d ? ST_AW_W : ST_AR;
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (rlast) state_d = ST_IDLE;
        end
      end
      ST_AW_W: begin
        // Each channel's handshake is remembered so the two may complete in either order.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
      ST_B: if (bvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      ST_IDLE: m_addr_ok = gnt;
      ST_AR:   arvalid = 1'b1;
      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          m_data_ok = gnt_q;
          m_rdata   = rdata;
          m_rlast   = rlast;
        end
      end
      ST_AW_W: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) m_data_ok = gnt_q;
      end
      default: ;
    endcase
  end

  assign arid    = {1'b0, g_q};
  assign araddr  = addr_q;
  assign arlen   = rlen_q;
  assign arsize  = axi_size(size_q);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = {1'b0, g_q};
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = axi_size(size_q);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = {1'b0, g_q};
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_from(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;

endmodule
